// File: rtl/wb_arbiter.sv
// Writeback arbiter: two sources (ALU = 0, LSU = 1) share the single regfile
// write port. Round-robin on contention, one registered write per cycle, and
// the in-flight write is forwarded onto both decode read paths.
module wb_arbiter #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  output logic              lsu_ready,
  output logic              rd_we,
  output logic [REG_AW-1:0] writeReg,
  output logic [XLEN-1:0]   writeData,
  input  logic [REG_AW-1:0] readReg1,
  input  logic [REG_AW-1:0] readReg2,
  input  logic [XLEN-1:0]   regOut1,
  input  logic [XLEN-1:0]   regOut2,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  output logic              last_grant
);

  logic              grant_alu;
  logic              grant_lsu;
  logic              rd_we_q,      rd_we_d;
  logic [REG_AW-1:0] write_reg_q,  write_reg_d;
  logic [XLEN-1:0]   write_data_q, write_data_d;
  logic              last_grant_q, last_grant_d;

  // Grant: blocked by stall or reset; on contention the source that did not
  // win last time goes first.
  always_comb begin
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    if (!hold && !rst) begin
      if (alu_valid && lsu_valid) begin
        grant_alu = last_grant_q;
        grant_lsu = !last_grant_q;
      end else begin
        grant_alu = alu_valid;
        grant_lsu = lsu_valid;
      end
    end
  end

  assign alu_ready = grant_alu;
  assign lsu_ready = grant_lsu;

  // Next write-port state: capture the granted result; a write to x0 is
  // swallowed (no enable, data cleared) but still counts as a grant.
  always_comb begin
    rd_we_d      = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    last_grant_d = last_grant_q;
    if (grant_alu) begin
      write_reg_d  = alu_rd;
      last_grant_d = 1'b0;
      rd_we_d      = (alu_rd != '0);
      write_data_d = (alu_rd != '0) ? alu_data : '0;
    end else if (grant_lsu) begin
      write_reg_d  = lsu_rd;
      last_grant_d = 1'b1;
      rd_we_d      = (lsu_rd != '0);
      write_data_d = (lsu_rd != '0) ? lsu_data : '0;
    end
  end

  // Write-port registers; last_grant resets to LSU so the ALU wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_we_q      <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      last_grant_q <= 1'b1;
    end else begin
      rd_we_q      <= rd_we_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rd_we      = rd_we_q;
  assign writeReg   = write_reg_q;
  assign writeData  = write_data_q;
  assign last_grant = last_grant_q;

  // Forward the write that lands at the end of this cycle; x0 is never forwarded.
  always_comb begin
    rs1_data = regOut1;
    rs2_data = regOut2;
    if (rd_we_q && (write_reg_q == readReg1) && (readReg1 != '0)) rs1_data = write_data_q;
    if (rd_we_q && (write_reg_q == readReg2) && (readReg2 != '0)) rs2_data = write_data_q;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table with explicit expectations,
// a write-port scoreboard checked every cycle, and a randomized handshake run.
module tb_wb_arbiter;

  localparam logic [31:0] A1 = 32'hAAAA0001;
  localparam logic [31:0] B2 = 32'hBBBB0002;

  logic        clk = 1'b0;
  logic        rst, hold;
  logic        alu_valid, lsu_valid;
  logic [4:0]  alu_rd, lsu_rd, readReg1, readReg2;
  logic [31:0] alu_data, lsu_data, regOut1, regOut2;
  logic        alu_ready, lsu_ready, rd_we, last_grant;
  logic [4:0]  writeReg;
  logic [31:0] writeData, rs1_data, rs2_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rd_we(rd_we), .writeReg(writeReg), .writeData(writeData),
    .readReg1(readReg1), .readReg2(readReg2), .regOut1(regOut1), .regOut2(regOut2),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .last_grant(last_grant)
  );

  typedef struct {
    logic        rst, hold, av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic [4:0]  rr1, rr2;
    logic [31:0] ro2;
    logic        ear, elr, ewe;
    logic [4:0]  ewr;
    logic [31:0] ewd, ers1, ers2;
    logic        elg;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
  } wr_t;

  vec_t vq[$];
  wr_t  sb[$];

  logic        m_last = 1'b1;
  logic [4:0]  m_wr   = '0;
  logic [31:0] m_wd   = '0;
  logic        prv_ok = 1'b0;
  logic        prv_av, prv_ag, prv_lv, prv_lg;
  logic [4:0]  prv_ard, prv_lrd;
  logic [31:0] prv_adat, prv_ldat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, h, av, input logic [4:0] ard, input logic [31:0] adat,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                     input logic [4:0] rr1, rr2, input logic [31:0] ro2,
                     input logic ear, elr, ewe, input logic [4:0] ewr,
                     input logic [31:0] ewd, ers1, ers2, input logic elg);
    vec_t v;
    v.rst = r; v.hold = h; v.av = av; v.ard = ard; v.adat = adat;
    v.lv = lv; v.lrd = lrd; v.ldat = ldat; v.rr1 = rr1; v.rr2 = rr2; v.ro2 = ro2;
    v.ear = ear; v.elr = elr; v.ewe = ewe; v.ewr = ewr; v.ewd = ewd;
    v.ers1 = ers1; v.ers2 = ers2; v.elg = elg;
    vq.push_back(v);
  endtask

  // Called at the negedge: compare against the scoreboard and push the
  // write-port state expected after the coming posedge.
  task automatic check_cycle(input string tag);
    wr_t  e, n;
    logic ga, gl;
    ga = !rst && !hold && alu_valid && (!lsu_valid || m_last);
    gl = !rst && !hold && lsu_valid && (!alu_valid || !m_last);
    chk($sformatf("%s sb alu_ready", tag), 32'(alu_ready), 32'(ga));
    chk($sformatf("%s sb lsu_ready", tag), 32'(lsu_ready), 32'(gl));
    if (prv_ok && prv_av && !prv_ag) begin
      chk($sformatf("%s alu held valid/rd", tag), {26'd0, alu_valid, alu_rd}, {26'd0, 1'b1, prv_ard});
      chk($sformatf("%s alu held data", tag), alu_data, prv_adat);
    end
    if (prv_ok && prv_lv && !prv_lg) begin
      chk($sformatf("%s lsu held valid/rd", tag), {26'd0, lsu_valid, lsu_rd}, {26'd0, 1'b1, prv_lrd});
      chk($sformatf("%s lsu held data", tag), lsu_data, prv_ldat);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("%s sb rd_we", tag), 32'(rd_we), 32'(e.we));
      chk($sformatf("%s sb writeReg", tag), 32'(writeReg), 32'(e.wr));
      chk($sformatf("%s sb writeData", tag), writeData, e.wd);
      chk($sformatf("%s sb last_grant", tag), 32'(last_grant), 32'(m_last));
      chk($sformatf("%s sb rs1_data", tag), rs1_data,
          (e.we && e.wr == readReg1 && readReg1 != 0) ? e.wd : regOut1);
      chk($sformatf("%s sb rs2_data", tag), rs2_data,
          (e.we && e.wr == readReg2 && readReg2 != 0) ? e.wd : regOut2);
    end
    if (rst) begin
      n.we = 1'b0; n.wr = '0; n.wd = '0; m_last = 1'b1;
    end else if (ga) begin
      n.we = (alu_rd != 0); n.wr = alu_rd; n.wd = (alu_rd != 0) ? alu_data : '0; m_last = 1'b0;
    end else if (gl) begin
      n.we = (lsu_rd != 0); n.wr = lsu_rd; n.wd = (lsu_rd != 0) ? lsu_data : '0; m_last = 1'b1;
    end else begin
      n.we = 1'b0; n.wr = m_wr; n.wd = m_wd;
    end
    m_wr = n.wr; m_wd = n.wd;
    sb.push_back(n);
    prv_ok = !rst;
    prv_av = alu_valid; prv_ag = ga; prv_ard = alu_rd; prv_adat = alu_data;
    prv_lv = lsu_valid; prv_lg = gl; prv_lrd = lsu_rd; prv_ldat = lsu_data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit pa, pl;
    rst = 1'b1; hold = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    readReg1 = '0; readReg2 = '0; regOut1 = A1; regOut2 = B2;

    // Reset held for two cycles.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); check_cycle($sformatf("rst%0d", i));
      @(posedge clk); #1;
    end

    //  rst  hold av ard    adat           lv lrd    ldat          rr1    rr2    ro2           ar lr we wr     wd             rs1            rs2            lg
    add(0, 0, 0, 5'd0, 32'h0,         0, 5'd0, 32'h0,     5'd0, 5'd0, B2,           0, 0, 0, 5'd0, 32'h0,         A1,            B2,            1);
    add(0, 0, 1, 5'd5, 32'hDEADBEEF,  0, 5'd0, 32'h0,     5'd0, 5'd0, B2,           1, 0, 0, 5'd0, 32'h0,         A1,            B2,            1);
    add(0, 0, 0, 5'd0, 32'h0,         0, 5'd0, 32'h0,     5'd5, 5'd0, B2,           0, 0, 1, 5'd5, 32'hDEADBEEF,  32'hDEADBEEF,  B2,            0);
    add(0, 0, 0, 5'd0, 32'h0,         0, 5'd0, 32'h0,     5'd5, 5'd0, B2,           0, 0, 0, 5'd5, 32'hDEADBEEF,  A1,            B2,            0);
    add(1, 0, 1, 5'd1, 32'h11,        1, 5'd2, 32'h22,    5'd0, 5'd0, B2,           0, 0, 0, 5'd5, 32'hDEADBEEF,  A1,            B2,            0);
    add(0, 0, 1, 5'd1, 32'h11,        1, 5'd2, 32'h22,    5'd0, 5'd0, B2,           1, 0, 0, 5'd0, 32'h0,         A1,            B2,            1);
    add(0, 0, 1, 5'd1, 32'h11,        1, 5'd2, 32'h22,    5'd0, 5'd0, B2,           0, 1, 1, 5'd1, 32'h11,        A1,            B2,            0);
    add(0, 0, 1, 5'd1, 32'h11,        1, 5'd2, 32'h22,    5'd0, 5'd0, B2,           1, 0, 1, 5'd2, 32'h22,        A1,            B2,            1);
    add(0, 0, 1, 5'd1, 32'h11,        1, 5'd2, 32'h22,    5'd0, 5'd0, B2,           0, 1, 1, 5'd1, 32'h11,        A1,            B2,            0);
    add(0, 0, 1, 5'd1, 32'h11,        0, 5'd0, 32'h0,     5'd0, 5'd0, B2,           1, 0, 1, 5'd2, 32'h22,        A1,            B2,            1);
    add(0, 0, 0, 5'd0, 32'h0,         1, 5'd0, 32'h1234,  5'd0, 5'd1, B2,           0, 1, 1, 5'd1, 32'h11,        A1,            32'h11,        0);
    add(0, 0, 0, 5'd0, 32'h0,         0, 5'd0, 32'h0,     5'd0, 5'd0, B2,           0, 0, 0, 5'd0, 32'h0,         A1,            B2,            1);
    add(0, 0, 1, 5'd7, 32'hCAFE0001,  0, 5'd0, 32'h0,     5'd0, 5'd7, 32'h0,        1, 0, 0, 5'd0, 32'h0,         A1,            32'h0,         1);
    add(0, 0, 0, 5'd0, 32'h0,         0, 5'd0, 32'h0,     5'd0, 5'd7, 32'h0,        0, 0, 1, 5'd7, 32'hCAFE0001,  A1,            32'hCAFE0001,  0);
    add(0, 0, 0, 5'd0, 32'h0,         0, 5'd0, 32'h0,     5'd0, 5'd7, 32'h0,        0, 0, 0, 5'd7, 32'hCAFE0001,  A1,            32'h0,         0);
    add(0, 0, 1, 5'd3, 32'h33,        0, 5'd0, 32'h0,     5'd0, 5'd0, B2,           1, 0, 0, 5'd7, 32'hCAFE0001,  A1,            B2,            0);
    add(0, 1, 0, 5'd0, 32'h0,         1, 5'd4, 32'h44,    5'd3, 5'd0, B2,           0, 0, 1, 5'd3, 32'h33,        32'h33,        B2,            0);
    add(0, 1, 0, 5'd0, 32'h0,         1, 5'd4, 32'h44,    5'd3, 5'd0, B2,           0, 0, 0, 5'd3, 32'h33,        A1,            B2,            0);
    add(0, 0, 0, 5'd0, 32'h0,         1, 5'd4, 32'h44,    5'd0, 5'd0, B2,           0, 1, 0, 5'd3, 32'h33,        A1,            B2,            0);
    add(0, 0, 0, 5'd0, 32'h0,         0, 5'd0, 32'h0,     5'd4, 5'd0, B2,           0, 0, 1, 5'd4, 32'h44,        32'h44,        B2,            1);
    add(0, 0, 1, 5'd9, 32'h901,       1, 5'd9, 32'h902,   5'd0, 5'd0, B2,           1, 0, 0, 5'd4, 32'h44,        A1,            B2,            1);
    add(0, 0, 0, 5'd0, 32'h0,         1, 5'd9, 32'h902,   5'd9, 5'd0, B2,           0, 1, 1, 5'd9, 32'h901,       32'h901,       B2,            0);
    add(0, 0, 0, 5'd0, 32'h0,         0, 5'd0, 32'h0,     5'd9, 5'd0, B2,           0, 0, 1, 5'd9, 32'h902,       32'h902,       B2,            1);
    add(0, 0, 0, 5'd0, 32'h0,         0, 5'd0, 32'h0,     5'd9, 5'd0, B2,           0, 0, 0, 5'd9, 32'h902,       A1,            B2,            1);
    add(0, 0, 1, 5'd6, 32'h66,        0, 5'd0, 32'h0,     5'd0, 5'd0, B2,           1, 0, 0, 5'd9, 32'h902,       A1,            B2,            1);
    add(1, 0, 1, 5'd1, 32'h11,        1, 5'd2, 32'h22,    5'd6, 5'd0, B2,           0, 0, 1, 5'd6, 32'h66,        32'h66,        B2,            0);
    add(0, 0, 0, 5'd0, 32'h0,         0, 5'd0, 32'h0,     5'd6, 5'd0, B2,           0, 0, 0, 5'd0, 32'h0,         A1,            B2,            1);

    foreach (vq[i]) begin
      rst = vq[i].rst; hold = vq[i].hold;
      alu_valid = vq[i].av; alu_rd = vq[i].ard; alu_data = vq[i].adat;
      lsu_valid = vq[i].lv; lsu_rd = vq[i].lrd; lsu_data = vq[i].ldat;
      readReg1 = vq[i].rr1; readReg2 = vq[i].rr2; regOut1 = A1; regOut2 = vq[i].ro2;
      @(negedge clk);
      chk($sformatf("v%0d alu_ready", i),  32'(alu_ready),  32'(vq[i].ear));
      chk($sformatf("v%0d lsu_ready", i),  32'(lsu_ready),  32'(vq[i].elr));
      chk($sformatf("v%0d rd_we", i),      32'(rd_we),      32'(vq[i].ewe));
      chk($sformatf("v%0d writeReg", i),   32'(writeReg),   32'(vq[i].ewr));
      chk($sformatf("v%0d writeData", i),  writeData,       vq[i].ewd);
      chk($sformatf("v%0d rs1_data", i),   rs1_data,        vq[i].ers1);
      chk($sformatf("v%0d rs2_data", i),   rs2_data,        vq[i].ers2);
      chk($sformatf("v%0d last_grant", i), 32'(last_grant), 32'(vq[i].elg));
      check_cycle($sformatf("v%0d", i));
      @(posedge clk); #1;
    end

    // Randomized traffic: a refused source keeps its request unchanged.
    pa = 1'b0; pl = 1'b0;
    for (int c = 0; c < 300; c++) begin
      rst = 1'b0;
      hold = ($urandom_range(0, 5) == 0);
      if (!pa) begin
        alu_valid = 1'($urandom_range(0, 1)); alu_rd = 5'($urandom_range(0, 7)); alu_data = $urandom;
      end
      if (!pl) begin
        lsu_valid = 1'($urandom_range(0, 1)); lsu_rd = 5'($urandom_range(0, 7)); lsu_data = $urandom;
      end
      readReg1 = 5'($urandom_range(0, 7)); readReg2 = 5'($urandom_range(0, 7));
      regOut1 = $urandom; regOut2 = $urandom;
      @(negedge clk);
      pa = alu_valid && !alu_ready;
      pl = lsu_valid && !lsu_ready;
      check_cycle($sformatf("r%0d", c));
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
